// File: rtl/half_adder_pkg.sv
// half_adder_pkg
//   Shared definitions for the half-adder checker:
//     state_t      - checker FSM states
//     NUM_VECTORS  - number of exhaustive input vectors for a 2-input block
//     ha_expect()  - golden half-adder model, returns {carry, s}
package half_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 4;

    function automatic logic [1:0] ha_expect(input logic a_in, input logic b_in);
        return {a_in & b_in, a_in ^ b_in};
    endfunction

endpackage

// File: rtl/half_adder_checker.sv
// half_adder_checker
//   Self-checking stimulus engine for a half adder. A start in IDLE launches
//   one run over the four vectors 00, 01, 10, 11 (a = vec[1], b = vec[0]).
//   Each vector is held SETTLE cycles in APPLY, then one CHECK cycle whose
//   closing edge samples s/carry against the golden model.
//
//   Handshake: start is a level sampled on the rising edge while in IDLE
//   only; it is neither queued nor acknowledged. done is a one-cycle pulse
//   marking the end of a run; pass/err_count/fail_vec stay valid until the
//   next accepted start.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         launch one run (honoured in IDLE only)
//   a, b          drive the half-adder inputs (registered)
//   s, carry      half-adder outputs under test
//   busy          high from the first APPLY cycle through the DONE cycle
//   done          one-cycle pulse in DONE
//   pass          last run had no mismatches
//   err_count     mismatches in the last run (0..4)
//   fail_vec      bit i set when vector i mismatched
//   dbg_state     current FSM state, for checkers and debug
module half_adder_checker
    import half_adder_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       s,
    input  logic       carry,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec,
    output logic [1:0] dbg_state
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] settle_q, settle_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;
    logic       pass_q, pass_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [1:0] expect_cs;
    logic       mismatch;
    logic       drive;

    // a_q/b_q hold the vector being checked, so compare against them.
    assign expect_cs = ha_expect(a_q, b_q);
    assign mismatch  = (s != expect_cs[0]) || (carry != expect_cs[1]);

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        fail_d   = fail_q;
        pass_d   = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_APPLY;
                    vec_d    = 2'd0;
                    err_d    = 3'd0;
                    fail_d   = 4'd0;
                    pass_d   = 1'b0;
                    settle_d = SETTLE_LOAD;
                end
            end
            ST_APPLY: begin
                if (settle_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_d         = err_q + 3'd1;
                    fail_d[vec_q] = 1'b1;
                end
                if (vec_q == LAST_VEC) begin
                    state_d = ST_DONE;
                end else begin
                    state_d  = ST_APPLY;
                    vec_d    = vec_q + 2'd1;
                    settle_d = SETTLE_LOAD;
                end
            end
            ST_DONE: begin
                // err_q already includes the last CHECK update here.
                pass_d  = (err_q == 3'd0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        drive  = (state_d == ST_APPLY) || (state_d == ST_CHECK);
        a_d    = drive & vec_d[1];
        b_d    = drive & vec_d[0];
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            vec_q    <= 2'd0;
            settle_q <= 4'd0;
            err_q    <= 3'd0;
            fail_q   <= 4'd0;
            pass_q   <= 1'b0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
            pass_q   <= pass_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_half_adder_checker.sv
// tb_half_adder_checker
//   Two checker instances (SETTLE = 1 and SETTLE = 3), each wired to a
//   behavioural half adder whose outputs can be corrupted via a mode select:
//   0 = correct, 1 = carry stuck at 0, 2 = sum inverted.
module tb_half_adder_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start1, start3;
    logic [1:0] mode1, mode3;

    logic       a1, b1, s1, c1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] fail1;
    logic [1:0] st1;

    logic       a3, b3, s3, c3, busy3, done3, pass3;
    logic [2:0] err3;
    logic [3:0] fail3;
    logic [1:0] st3;

    assign s1 = (a1 ^ b1) ^ (mode1 == 2'd2);
    assign c1 = (mode1 == 2'd1) ? 1'b0 : (a1 & b1);
    assign s3 = (a3 ^ b3) ^ (mode3 == 2'd2);
    assign c3 = (mode3 == 2'd1) ? 1'b0 : (a3 & b3);

    half_adder_checker #(.SETTLE(1)) u_chk1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .s(s1), .carry(c1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_vec(fail1), .dbg_state(st1)
    );

    half_adder_checker #(.SETTLE(3)) u_chk3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .s(s3), .carry(c3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_vec(fail3), .dbg_state(st3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-derived a/b sequence for SETTLE = 1, cycles 1..8 after launch.
    logic [1:0] exp_ab1 [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 after the launch edge.
    task automatic launch1();
        start1 = 1'b1;
        step();
        start1 = 1'b0;
    endtask

    // Returns the cycle (counting the current one as 1) in which done1 is
    // seen, staying in that cycle; 0 if not seen within limit.
    task automatic wait_done1(input int limit, output int cyc);
        cyc = 0;
        for (int k = 1; k <= limit; k++) begin
            if (done1) begin
                cyc = k;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; mode1 = 2'd0; mode3 = 2'd0;
        step(); step();
        n_checks++;
        if ({a1, b1, busy1, done1, pass1, err1, fail1, st1} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_chk1: got %b expected 0", {a1, b1, busy1, done1, pass1, err1, fail1, st1});
        end
        n_checks++;
        if ({a3, b3, busy3, done3, pass3, err3, fail3, st3} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_chk3: got %b expected 0", {a3, b3, busy3, done3, pass3, err3, fail3, st3});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_clean_run();
        mode1 = 2'd0;
        launch1();
        for (int k = 1; k <= 8; k++) begin
            n_checks++;
            if ({a1, b1, busy1, done1} !== {exp_ab1[k-1], 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL clean_seq cycle %0d: a,b,busy,done=%b expected %b",
                         k, {a1, b1, busy1, done1}, {exp_ab1[k-1], 2'b10});
            end
            step();
        end
        n_checks++;
        if ({done1, busy1} !== 2'b11) begin
            n_fail++;
            $display("FAIL clean_done_cycle9: done,busy=%b expected 11", {done1, busy1});
        end
        step();
        n_checks++;
        if ({done1, busy1, a1, b1, pass1, err1, fail1} !== {4'b0000, 1'b1, 3'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL clean_result: done,busy,a,b,pass,err,fail=%b expected 0000_1_000_0000",
                     {done1, busy1, a1, b1, pass1, err1, fail1});
        end
    endtask

    task automatic test_carry_stuck();
        int cyc;
        mode1 = 2'd1;
        launch1();
        // pass from the previous clean run must clear on the accepted start
        n_checks++;
        if (pass1 !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_clear_on_start: got %b expected 0", pass1);
        end
        wait_done1(20, cyc);
        n_checks++;
        if (cyc != 9) begin
            n_fail++;
            $display("FAIL carry_done_cycle: got %0d expected 9", cyc);
        end
        step();
        n_checks++;
        if ({pass1, err1, fail1} !== {1'b0, 3'd1, 4'b1000}) begin
            n_fail++;
            $display("FAIL carry_stuck_result: pass,err,fail=%b expected 0_001_1000", {pass1, err1, fail1});
        end
        mode1 = 2'd0;
    endtask

    task automatic test_sum_inverted();
        int cyc;
        mode1 = 2'd2;
        launch1();
        wait_done1(20, cyc);
        n_checks++;
        if (cyc != 9) begin
            n_fail++;
            $display("FAIL suminv_done_cycle: got %0d expected 9", cyc);
        end
        step();
        n_checks++;
        if ({pass1, err1, fail1} !== {1'b0, 3'd4, 4'b1111}) begin
            n_fail++;
            $display("FAIL sum_inverted_result: pass,err,fail=%b expected 0_100_1111", {pass1, err1, fail1});
        end
        mode1 = 2'd0;
    endtask

    task automatic test_mid_run_reset();
        int cyc;
        int n_done;
        mode1 = 2'd0;
        launch1();
        repeat (5) step();          // now in cycle 6: vector 2 CHECK
        n_checks++;
        if ({st1, a1, b1} !== {2'd2, 2'b10}) begin
            n_fail++;
            $display("FAIL midrst_in_check2: state,a,b=%b expected 1010", {st1, a1, b1});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({a1, b1, busy1, done1, pass1, err1, fail1, st1} !== 14'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %b expected 0", {a1, b1, busy1, done1, pass1, err1, fail1, st1});
        end
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            if (done1) n_done++;
            step();
        end
        n_checks++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL midrst_no_done: got %0d done pulses expected 0", n_done);
        end
        launch1();
        wait_done1(20, cyc);
        step();
        n_checks++;
        if ({pass1, err1, fail1} !== {1'b1, 3'd0, 4'b0000} || cyc != 9) begin
            n_fail++;
            $display("FAIL midrst_rerun: pass,err,fail=%b done_cycle=%0d expected 1_000_0000 and 9",
                     {pass1, err1, fail1}, cyc);
        end
    endtask

    task automatic test_rst_start_same_cycle();
        rst = 1'b1; start1 = 1'b1;
        step();
        rst = 1'b0; start1 = 1'b0;
        step();
        n_checks++;
        if ({busy1, st1} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_beats_start: busy,state=%b expected 000", {busy1, st1});
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start1 = 1'b1;
        step();                     // cycle 1 of first run
        wait_done1(20, cyc);        // in DONE (cycle 9)
        n_checks++;
        if (cyc != 9) begin
            n_fail++;
            $display("FAIL b2b_first_done: got %0d expected 9", cyc);
        end
        step();                     // cycle 10: IDLE, start sampled
        n_checks++;
        if ({busy1, pass1} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: busy,pass=%b expected 01", {busy1, pass1});
        end
        step();                     // cycle 11: second run APPLY
        start1 = 1'b0;
        n_checks++;
        if ({busy1, a1, b1, st1} !== {3'b100, 2'd1}) begin
            n_fail++;
            $display("FAIL b2b_relaunch: busy,a,b,state=%b expected 10001", {busy1, a1, b1, st1});
        end
        wait_done1(20, cyc);
        step();
        n_checks++;
        if ({pass1, busy1} !== 2'b10 || cyc != 9) begin
            n_fail++;
            $display("FAIL b2b_second_run: pass,busy=%b done_cycle=%0d expected 10 and 9", {pass1, busy1}, cyc);
        end
    endtask

    task automatic test_settle3_restart();
        int n_done;
        int done_at;
        int v;
        mode3 = 2'd0;
        n_done = 0;
        done_at = 0;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if (k == 5) start3 = 1'b1;
            if (k == 6) start3 = 1'b0;
            if (done3) begin
                n_done++;
                done_at = k;
            end
            if (k <= 16) begin
                v = (k - 1) / 4;
                n_checks++;
                if ({a3, b3, busy3} !== {2'(v), 1'b1}) begin
                    n_fail++;
                    $display("FAIL s3_seq cycle %0d: a,b,busy=%b expected %b", k, {a3, b3, busy3}, {2'(v), 1'b1});
                end
            end
            step();
        end
        n_checks++;
        if (n_done != 1 || done_at != 17) begin
            n_fail++;
            $display("FAIL s3_done: %0d pulses at cycle %0d expected 1 at 17", n_done, done_at);
        end
        n_checks++;
        if ({pass3, err3, fail3, busy3} !== {1'b1, 3'd0, 4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL s3_result: pass,err,fail,busy=%b expected 1_000_0000_0", {pass3, err3, fail3, busy3});
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_carry_stuck();
        test_sum_inverted();
        test_mid_run_reset();
        test_rst_start_same_cycle();
        test_back_to_back();
        test_settle3_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
